micro_sequencer: RTL and testbench

Microprogram sequencer for the CISC-MIN control unit. Sits directly downstream of the instruction decoder: it consumes the decoder's registered IB_Address (instruction branch) and SB_Address (second branch) dispatch targets and produces the control-store address (uPC) each cycle. It also supports conditional branches, a small microsubroutine stack and memory-wait stalls, and it signals instruction completion back to fetch.

---
 rtl/micro_sequencer.sv | 112 +++++++++++
 tb/tb_micro_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer: uPC select, return stack, wait stall, fault trap
module micro_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4,
  parameter int FETCH_ADDR  = 0
) (
  input  logic              ClockInput,
  input  logic              ResetInput,
  input  logic [ADDR_W-1:0] IB_Address,
  input  logic [ADDR_W-1:0] SB_Address,
  input  logic [2:0]        NextSel,
  input  logic [ADDR_W-1:0] BranchAddr,
  input  logic              ZeroFlag,
  input  logic              MemWait,
  output logic [ADDR_W-1:0] uPC,
  output logic              InstrDone,
  output logic [2:0]        StackCount,
  output logic              StackFault
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] FETCH_C = ADDR_W'(FETCH_ADDR);

  localparam logic [2:0] SEL_CONT  = 3'd0;
  localparam logic [2:0] SEL_JUMP  = 3'd1;
  localparam logic [2:0] SEL_IB    = 3'd2;
  localparam logic [2:0] SEL_SB    = 3'd3;
  localparam logic [2:0] SEL_BZ    = 3'd4;
  localparam logic [2:0] SEL_CALL  = 3'd5;
  localparam logic [2:0] SEL_RET   = 3'd6;
  localparam logic [2:0] SEL_FETCH = 3'd7;

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  upc_q, upc_d, upc_inc;
  logic [CNT_W-1:0]   cnt_q;
  logic               fault_q, fault_set;
  logic               push, pop;
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

  assign upc_inc = upc_q + 1'b1;

  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      state_q <= RUN;
      upc_q   <= FETCH_C;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      if (fault_set) fault_q <= 1'b1;
      if (push) begin
        stack_mem[PTR_W'(cnt_q)] <= upc_inc;
        cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Only RUN without a memory wait advances; FAULT and stalls hold everything.
  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
    InstrDone = 1'b0;
    if (state_q == RUN && !MemWait) begin
      case (NextSel)
        SEL_CONT:  upc_d = upc_inc;
        SEL_JUMP:  upc_d = BranchAddr;
        SEL_IB:    upc_d = IB_Address;
        SEL_SB:    upc_d = SB_Address;
        SEL_BZ:    upc_d = ZeroFlag ? BranchAddr : upc_inc;
        SEL_CALL: begin
          if (cnt_q == DEPTH_C) begin
            fault_set = 1'b1;
            state_d   = FAULT;
          end else begin
            push  = 1'b1;
            upc_d = BranchAddr;
          end
        end
        SEL_RET: begin
          if (cnt_q == '0) begin
            fault_set = 1'b1;
            state_d   = FAULT;
          end else begin
            pop   = 1'b1;
            upc_d = stack_mem[PTR_W'(cnt_q - 1'b1)];
          end
        end
        SEL_FETCH: begin
          upc_d     = FETCH_C;
          InstrDone = 1'b1;
        end
        default:   upc_d = upc_q;
      endcase
    end
  end

  assign uPC        = upc_q;
  assign StackCount = 3'(cnt_q);
  assign StackFault = fault_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench for micro_sequencer
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       ResetInput;
  logic [5:0] IB_Address, SB_Address, BranchAddr, uPC;
  logic [2:0] NextSel, StackCount;
  logic       ZeroFlag, MemWait, InstrDone, StackFault;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic [5:0] br;
    logic       zf;
    logic       mw;
  } stim_t;

  typedef struct packed {
    logic [5:0] upc;
    logic [2:0] cnt;
    logic       fault;
    logic       done;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb[$];

  localparam logic [2:0] CONT = 3'd0, JUMP = 3'd1, DIB = 3'd2, DSB = 3'd3,
                         BZ = 3'd4, CALL = 3'd5, RET = 3'd6, FETCH = 3'd7;

  micro_sequencer #(.ADDR_W(6), .STACK_DEPTH(4), .FETCH_ADDR(0)) dut (
    .ClockInput (clk),
    .ResetInput (ResetInput),
    .IB_Address (IB_Address),
    .SB_Address (SB_Address),
    .NextSel    (NextSel),
    .BranchAddr (BranchAddr),
    .ZeroFlag   (ZeroFlag),
    .MemWait    (MemWait),
    .uPC        (uPC),
    .InstrDone  (InstrDone),
    .StackCount (StackCount),
    .StackFault (StackFault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic [2:0] sel, input logic [5:0] br, input logic zf, input logic mw,
                     input logic [5:0] eu, input logic [2:0] ec, input logic ef, input logic ed);
    stim_q.push_back('{sel: sel, br: br, zf: zf, mw: mw});
    sb.push_back('{upc: eu, cnt: ec, fault: ef, done: ed});
  endtask

  // InstrDone is sampled before the edge; state after it.
  task automatic cycle(input stim_t s, output logic done_obs);
    NextSel    = s.sel;
    BranchAddr = s.br;
    ZeroFlag   = s.zf;
    MemWait    = s.mw;
    #1 done_obs = InstrDone;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    NextSel = CONT; BranchAddr = '0; ZeroFlag = 1'b0; MemWait = 1'b0;
    ResetInput = 1'b1;
    @(posedge clk);
    #1 ResetInput = 1'b0;
  endtask

  task automatic test_reset;
    stim_t s; exp_t e; logic d;
    NextSel = CONT; BranchAddr = '0; ZeroFlag = 1'b0; MemWait = 1'b0;
    IB_Address = 6'd15; SB_Address = 6'd6;
    ResetInput = 1'b1;
    #1;
    vectors++;
    if (uPC !== 6'd0 || StackCount !== 3'd0 || StackFault !== 1'b0 || InstrDone !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init: got upc=%0d cnt=%0d fault=%b done=%b, want 0 0 0 0",
               uPC, StackCount, StackFault, InstrDone);
    end
    @(posedge clk);
    #1 ResetInput = 1'b0;
    add(CALL, 6'd5,  0, 0, 6'd5,  3'd1, 0, 0);
    add(CALL, 6'd26, 0, 0, 6'd26, 3'd2, 0, 0);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cycle(s, d); e = sb.pop_front(); vectors++;
      if (uPC !== e.upc || StackCount !== e.cnt || StackFault !== e.fault || d !== e.done) begin
        miscompares++;
        $display("FAIL reset_setup[%0d]: got upc=%0d cnt=%0d fault=%b done=%b, want upc=%0d cnt=%0d fault=%b done=%b",
                 k, uPC, StackCount, StackFault, d, e.upc, e.cnt, e.fault, e.done);
      end
    end
    ResetInput = 1'b1;
    #1;
    vectors++;
    if (uPC !== 6'd0 || StackCount !== 3'd0 || StackFault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: got upc=%0d cnt=%0d fault=%b, want 0 0 0",
               uPC, StackCount, StackFault);
    end
    #1 ResetInput = 1'b0;
  endtask

  task automatic test_dispatch;
    stim_t s; exp_t e; logic d;
    apply_reset();
    IB_Address = 6'd15; SB_Address = 6'd6;
    add(CONT, 6'd0, 0, 0, 6'd1,  3'd0, 0, 0);
    add(DIB,  6'd0, 0, 0, 6'd15, 3'd0, 0, 0);
    add(DSB,  6'd0, 0, 0, 6'd6,  3'd0, 0, 0);
    add(JUMP, 6'd33, 0, 0, 6'd33, 3'd0, 0, 0);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cycle(s, d); e = sb.pop_front(); vectors++;
      if (uPC !== e.upc || StackCount !== e.cnt || StackFault !== e.fault || d !== e.done) begin
        miscompares++;
        $display("FAIL dispatch[%0d]: got upc=%0d cnt=%0d fault=%b done=%b, want upc=%0d cnt=%0d fault=%b done=%b",
                 k, uPC, StackCount, StackFault, d, e.upc, e.cnt, e.fault, e.done);
      end
    end
  endtask

  task automatic test_branch;
    stim_t s; exp_t e; logic d;
    apply_reset();
    add(JUMP, 6'd20, 0, 0, 6'd20, 3'd0, 0, 0);
    add(BZ,   6'd11, 1, 0, 6'd11, 3'd0, 0, 0);
    add(JUMP, 6'd20, 0, 0, 6'd20, 3'd0, 0, 0);
    add(BZ,   6'd11, 0, 0, 6'd21, 3'd0, 0, 0);
    add(JUMP, 6'd63, 0, 0, 6'd63, 3'd0, 0, 0);
    add(CONT, 6'd0,  0, 0, 6'd0,  3'd0, 0, 0);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cycle(s, d); e = sb.pop_front(); vectors++;
      if (uPC !== e.upc || StackCount !== e.cnt || StackFault !== e.fault || d !== e.done) begin
        miscompares++;
        $display("FAIL branch[%0d]: got upc=%0d cnt=%0d fault=%b done=%b, want upc=%0d cnt=%0d fault=%b done=%b",
                 k, uPC, StackCount, StackFault, d, e.upc, e.cnt, e.fault, e.done);
      end
    end
  endtask

  task automatic test_call_ret;
    stim_t s; exp_t e; logic d;
    apply_reset();
    add(JUMP,  6'd9,  0, 0, 6'd9,  3'd0, 0, 0);
    add(CALL,  6'd32, 0, 0, 6'd32, 3'd1, 0, 0);
    add(RET,   6'd0,  0, 0, 6'd10, 3'd0, 0, 0);
    add(CALL,  6'd40, 0, 0, 6'd40, 3'd1, 0, 0);
    add(CALL,  6'd41, 0, 0, 6'd41, 3'd2, 0, 0);
    add(CALL,  6'd42, 0, 0, 6'd42, 3'd3, 0, 0);
    add(CALL,  6'd43, 0, 0, 6'd43, 3'd4, 0, 0);
    add(CALL,  6'd44, 0, 0, 6'd43, 3'd4, 1, 0);
    add(JUMP,  6'd1,  0, 0, 6'd43, 3'd4, 1, 0);
    add(RET,   6'd0,  0, 0, 6'd43, 3'd4, 1, 0);
    add(FETCH, 6'd0,  0, 0, 6'd43, 3'd4, 1, 0);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cycle(s, d); e = sb.pop_front(); vectors++;
      if (uPC !== e.upc || StackCount !== e.cnt || StackFault !== e.fault || d !== e.done) begin
        miscompares++;
        $display("FAIL call_ret[%0d]: got upc=%0d cnt=%0d fault=%b done=%b, want upc=%0d cnt=%0d fault=%b done=%b",
                 k, uPC, StackCount, StackFault, d, e.upc, e.cnt, e.fault, e.done);
      end
    end
  endtask

  task automatic test_underflow;
    stim_t s; exp_t e; logic d;
    apply_reset();
    add(CONT,  6'd0, 0, 0, 6'd1, 3'd0, 0, 0);
    add(RET,   6'd0, 0, 0, 6'd1, 3'd0, 1, 0);
    add(CONT,  6'd0, 0, 0, 6'd1, 3'd0, 1, 0);
    add(CALL,  6'd7, 0, 0, 6'd1, 3'd0, 1, 0);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cycle(s, d); e = sb.pop_front(); vectors++;
      if (uPC !== e.upc || StackCount !== e.cnt || StackFault !== e.fault || d !== e.done) begin
        miscompares++;
        $display("FAIL underflow[%0d]: got upc=%0d cnt=%0d fault=%b done=%b, want upc=%0d cnt=%0d fault=%b done=%b",
                 k, uPC, StackCount, StackFault, d, e.upc, e.cnt, e.fault, e.done);
      end
    end
  endtask

  task automatic test_memwait;
    stim_t s; exp_t e; logic d;
    apply_reset();
    add(JUMP, 6'd12, 0, 0, 6'd12, 3'd0, 0, 0);
    add(RET,  6'd0,  0, 1, 6'd12, 3'd0, 0, 0);
    add(CALL, 6'd50, 0, 1, 6'd12, 3'd0, 0, 0);
    add(CALL, 6'd50, 0, 1, 6'd12, 3'd0, 0, 0);
    add(CALL, 6'd50, 0, 1, 6'd12, 3'd0, 0, 0);
    add(CALL, 6'd50, 0, 0, 6'd50, 3'd1, 0, 0);
    add(CONT, 6'd0,  0, 0, 6'd51, 3'd1, 0, 0);
    add(RET,  6'd0,  0, 0, 6'd13, 3'd0, 0, 0);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cycle(s, d); e = sb.pop_front(); vectors++;
      if (uPC !== e.upc || StackCount !== e.cnt || StackFault !== e.fault || d !== e.done) begin
        miscompares++;
        $display("FAIL memwait[%0d]: got upc=%0d cnt=%0d fault=%b done=%b, want upc=%0d cnt=%0d fault=%b done=%b",
                 k, uPC, StackCount, StackFault, d, e.upc, e.cnt, e.fault, e.done);
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t s; exp_t e; logic d;
    apply_reset();
    add(JUMP,  6'd27, 0, 0, 6'd27, 3'd0, 0, 0);
    add(FETCH, 6'd0,  0, 0, 6'd0,  3'd0, 0, 1);
    add(CONT,  6'd0,  0, 0, 6'd1,  3'd0, 0, 0);
    add(FETCH, 6'd0,  0, 1, 6'd1,  3'd0, 0, 0);
    add(FETCH, 6'd0,  0, 1, 6'd1,  3'd0, 0, 0);
    add(FETCH, 6'd0,  0, 0, 6'd0,  3'd0, 0, 1);
    add(FETCH, 6'd0,  0, 0, 6'd0,  3'd0, 0, 1);
    add(CONT,  6'd0,  0, 0, 6'd1,  3'd0, 0, 0);
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cycle(s, d); e = sb.pop_front(); vectors++;
      if (uPC !== e.upc || StackCount !== e.cnt || StackFault !== e.fault || d !== e.done) begin
        miscompares++;
        $display("FAIL fetch[%0d]: got upc=%0d cnt=%0d fault=%b done=%b, want upc=%0d cnt=%0d fault=%b done=%b",
                 k, uPC, StackCount, StackFault, d, e.upc, e.cnt, e.fault, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_branch();
    test_call_ret();
    test_underflow();
    test_memwait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
